// File: rtl/riscv_pkg.sv
// Shared riscv32 definitions: datapath width, opcodes and instruction field positions.
// Also imported by the ALU.
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_AW   = 5;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned OPCODE_W   = 7;
    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned RD_W       = 5;

    // True for opcodes whose result lands in rd.
    function automatic logic writes_rd(input logic [6:0] opcode);
        logic w;
        case (opcode)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
            OPC_JAL, OPC_JALR, OPC_LOAD:           w = 1'b1;
            default:                               w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/riscv_writeback_if.sv
// Writeback stage bus: completed-instruction input, operand read ports and commit status.
interface riscv_writeback_if
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = riscv_pkg::XLEN
) ();

    logic                valid_in;
    logic [31:0]         iw_in;
    logic [XLEN-1:0]     alu_result_in;
    logic [REG_AW-1:0]   rs1_addr;
    logic [REG_AW-1:0]   rs2_addr;
    logic [XLEN-1:0]     rs1_data_out;
    logic [XLEN-1:0]     rs2_data_out;
    logic                wb_valid;
    logic [REG_AW-1:0]   wb_rd;
    logic [XLEN-1:0]     wb_data;
    logic [31:0]         retire_count;

    modport master (
        output valid_in, iw_in, alu_result_in, rs1_addr, rs2_addr,
        input  rs1_data_out, rs2_data_out, wb_valid, wb_rd, wb_data, retire_count
    );

    modport slave (
        input  valid_in, iw_in, alu_result_in, rs1_addr, rs2_addr,
        output rs1_data_out, rs2_data_out, wb_valid, wb_rd, wb_data, retire_count
    );

endinterface

// File: rtl/riscv_regfile.sv
// 32 x XLEN integer register file: one synchronous write port, two combinational
// read ports, x0 hardwired to zero, synchronous clear.
module riscv_regfile
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = riscv_pkg::XLEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2
);

    logic [XLEN-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];
    end

endmodule

// File: rtl/riscv_writeback.sv
// Writeback stage: decodes rd writes, holds one pending write for a cycle, commits it to
// the register file and forwards it to the operand read ports meanwhile.
module riscv_writeback
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN       = riscv_pkg::XLEN,
    parameter bit          FORWARD_EN = 1'b1
) (
    input logic               clk,
    input logic               reset,
    riscv_writeback_if.slave  bus
);

    logic [OPCODE_W-1:0] opcode;
    logic [RD_W-1:0]     rd;
    logic                accept;

    logic                wb_valid_q;
    logic [RD_W-1:0]     wb_rd_q;
    logic [XLEN-1:0]     wb_data_q;
    logic [31:0]         retire_count_q;

    logic [XLEN-1:0]     rf_rdata1;
    logic [XLEN-1:0]     rf_rdata2;

    // Upper instruction fields play no part in writeback.
    logic unused_iw;
    assign unused_iw = ^bus.iw_in[31:RD_LSB+RD_W];

    always_comb begin
        opcode = bus.iw_in[OPCODE_LSB +: OPCODE_W];
        rd     = bus.iw_in[RD_LSB +: RD_W];
        accept = bus.valid_in & writes_rd(opcode) & (rd != '0);
    end

    // rd/data are zeroed when nothing commits so the idle pending register is quiet.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            retire_count_q <= '0;
        end else begin
            wb_valid_q <= accept;
            wb_rd_q    <= accept ? rd : '0;
            wb_data_q  <= accept ? bus.alu_result_in : '0;
            if (wb_valid_q) begin
                retire_count_q <= retire_count_q + 32'd1;
            end
        end
    end

    riscv_regfile #(
        .XLEN (XLEN)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (wb_valid_q),
        .waddr  (wb_rd_q),
        .wdata  (wb_data_q),
        .raddr1 (bus.rs1_addr),
        .raddr2 (bus.rs2_addr),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

    always_comb begin
        bus.rs1_data_out = rf_rdata1;
        bus.rs2_data_out = rf_rdata2;
        if (FORWARD_EN && wb_valid_q) begin
            if ((bus.rs1_addr != '0) && (bus.rs1_addr == wb_rd_q)) begin
                bus.rs1_data_out = wb_data_q;
            end
            if ((bus.rs2_addr != '0) && (bus.rs2_addr == wb_rd_q)) begin
                bus.rs2_data_out = wb_data_q;
            end
        end
    end

    always_comb begin
        bus.wb_valid     = wb_valid_q;
        bus.wb_rd        = wb_rd_q;
        bus.wb_data      = wb_data_q;
        bus.retire_count = retire_count_q;
    end

endmodule

// File: doc/riscv_writeback.md
# riscv_writeback

Writeback stage and integer register file for the riscv32 core. Captures each ALU result together with the instruction word that produced it, decides from the opcode whether it updates `rd`, and commits it one cycle later. Serves two combinational read ports that supply the ALU's `rs1_data_in`/`rs2_data_in`, with forwarding from the pending writeback. This is the writer side of the operand path that the ALU reads.

## Interface
- `XLEN`, 32: datapath and register width.
- `FORWARD_EN`, 1: 1 enables forwarding from the pending writeback register to the read ports; 0 returns array contents only.

- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `valid_in` input 1: `alu_result_in`/`iw_in` hold a completed instruction this cycle.
- `iw_in` input 32: instruction word matching `alu_result_in`.
- `alu_result_in` input XLEN: ALU result for `iw_in`.
- `rs1_addr` input 5: read port 1 address.
- `rs2_addr` input 5: read port 2 address.
- `rs1_data_out` output XLEN: read port 1 data; drives ALU `rs1_data_in`.
- `rs2_data_out` output XLEN: read port 2 data; drives ALU `rs2_data_in`.
- `wb_valid` output 1: pending writeback register holds a committing write.
- `wb_rd` output 5: destination of the pending write.
- `wb_data` output XLEN: data of the pending write.
- `retire_count` output 32: number of committed register writes since reset.

## Operation
- Write decode from `iw_in[6:0]`. Writes `rd`: OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, LOAD 0000011.
- No write: STORE, BRANCH, SYSTEM, MISC-MEM, any unlisted opcode.
- `rd = iw_in[11:7]`. A write with `rd`=0 is treated as non-writing.
- Stage 1, pending register: on each edge, `wb_valid <= valid_in & writes & (rd!=0)`, `wb_rd <= rd`, `wb_data <= alu_result_in`. When `wb_valid` is 0, `wb_rd`/`wb_data` are don't-care but are held at 0.
- Stage 2, commit: on each edge where `wb_valid`=1, `regs[wb_rd] <= wb_data` and `retire_count` increments. `retire_count` wraps modulo 2^32.
- Read ports:
  - Address 0 always returns 0.
  - Otherwise, if `FORWARD_EN` and `wb_valid` and address equals `wb_rd`, return `wb_data`.
  - Otherwise return `regs[addr]`.
  - Both ports are independent and may share an address.
- Reset: `wb_valid`, `wb_rd`, `wb_data` = 0; `retire_count` = 0; all 31 registers cleared to 0 in the reset cycle. A pending write is discarded when `reset` is high.
- `reset` has priority over `valid_in` and over commit.

## Timing
- Result accepted at edge E is committed to the array at edge E+1.
- Between E and E+1 the result is visible on the read ports only via forwarding.
- Read ports are combinational from addresses and state, with zero added latency.
- Back-to-back `valid_in` is supported every cycle with no stall or backpressure.
- Same-`rd` consecutive writes: the newer one sits in the pending register and wins on reads; the array ends holding the newer value.
- With `FORWARD_EN`=0, a read of `rd` in the cycle after acceptance returns the old value.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN`, `NUM_REGS`=32.
  - Opcode localparams: `OPC_OP`, `OPC_OP_IMM`, `OPC_LUI`, `OPC_AUIPC`, `OPC_JAL`, `OPC_JALR`, `OPC_LOAD`, `OPC_STORE`, `OPC_BRANCH`, `OPC_SYSTEM`.
  - Instruction field slice constants.
  - The ALU reuses the same package.
- One sub-module, `riscv_regfile`: 32xXLEN array, one synchronous write port, two combinational read ports, x0 hardwired, synchronous clear on `reset`.
- Decode, pending register, forwarding mux and `retire_count` stay in the top of this block.

## Test plan
- Reset for 2 cycles, then read all addresses. Required: all reads 0, `wb_valid`=0, `retire_count`=0.
- `valid_in`=1, `iw_in`=0x00A00293 (addi x5,x0,10), `alu_result_in`=10, `rs1_addr`=5.
  - Next cycle: `wb_valid`=1, `wb_rd`=5, `rs1_data_out`=10 (forwarded).
  - Cycle after: `wb_valid`=0, `rs1_data_out`=10 from array, `retire_count`=1.
- `iw_in`=0x00512223 (sw x5,4(x2); bits[11:7]=4), `alu_result_in`=0xDEADBEEF. Required: `wb_valid` stays 0, x4 unchanged, count unchanged.
- `iw_in`=0x00100013 (addi x0,x0,1), result 1. Required: no write, read x0 = 0, count unchanged.
- Back-to-back writes to x7 with values 0x11 then 0x22. Required:
  - Port reads 0x11 then 0x22 on consecutive cycles.
  - Final array x7 = 0x22.
  - `retire_count` +2.
- Assert `reset` in the same cycle `wb_valid`=1 for x9 = 0x55. Required: x9 reads 0 after reset, `retire_count`=0, no commit.
